// File: rtl/controller_pkg.sv
// Shared types for the Sobel sequencing controller: state encoding and request bundle.
package controller_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned REQ_W   = 5;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    SHIFT = 3'd4,
    MOVE  = 3'd5
  } ctrl_state_t;

  typedef struct packed {
    logic move;
    logic shift;
    logic write;
    logic calc;
    logic read;
  } ctrl_req_t;

endpackage

// File: rtl/controller.sv
// Phase sequencer for the Sobel datapath: read, calc, write, shift, move per window.
// Optional CONTROLLER_FRAME_DONE_EN adds a one-cycle frame_done pulse after the last write.
module controller
  import controller_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic start,
  input  logic read_done,
  input  logic calculation_done,
  input  logic write_done,
  input  logic shift_done,
  input  logic move_done,
  input  logic all_done,
  output logic start_read,
  output logic start_calculation,
  output logic start_write,
  output logic start_shift,
  output logic start_move
`ifdef CONTROLLER_FRAME_DONE_EN
  ,
  output logic frame_done
`endif
);

  ctrl_state_t state_q, state_d;
  ctrl_req_t   req_q, req_d;
`ifdef CONTROLLER_FRAME_DONE_EN
  logic        frame_done_q, frame_done_d;
`endif

  // State and request registers; requests are decoded from the next state so they track state_q.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      req_q   <= '0;
`ifdef CONTROLLER_FRAME_DONE_EN
      frame_done_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
`ifdef CONTROLLER_FRAME_DONE_EN
      frame_done_q <= frame_done_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = '0;
`ifdef CONTROLLER_FRAME_DONE_EN
    frame_done_d = 1'b0;
`endif

    // Each phase only listens to its own done input.
    case (state_q)
      IDLE:  if (start)            state_d = READ;
      READ:  if (read_done)        state_d = CALC;
      CALC:  if (calculation_done) state_d = WRITE;
      WRITE: begin
        if (write_done) begin
          state_d = all_done ? IDLE : SHIFT;
`ifdef CONTROLLER_FRAME_DONE_EN
          frame_done_d = all_done;
`endif
        end
      end
      SHIFT: if (shift_done)       state_d = MOVE;
      MOVE:  if (move_done)        state_d = READ;
      default:                     state_d = IDLE;
    endcase

    case (state_d)
      READ:    req_d.read  = 1'b1;
      CALC:    req_d.calc  = 1'b1;
      WRITE:   req_d.write = 1'b1;
      SHIFT:   req_d.shift = 1'b1;
      MOVE:    req_d.move  = 1'b1;
      default: req_d       = '0;
    endcase
  end

  assign start_read        = req_q.read;
  assign start_calculation = req_q.calc;
  assign start_write       = req_q.write;
  assign start_shift       = req_q.shift;
  assign start_move        = req_q.move;
`ifdef CONTROLLER_FRAME_DONE_EN
  assign frame_done        = frame_done_q;
`endif

endmodule

// File: tb/tb_controller.sv
// Directed plus randomized bench for controller against a phase-counter reference model.
module tb_controller;

  logic clk = 1'b0;
  logic n_rst, start;
  logic read_done, calculation_done, write_done, shift_done, move_done, all_done;
  logic start_read, start_calculation, start_write, start_shift, start_move;
`ifdef CONTROLLER_FRAME_DONE_EN
  logic frame_done;
`endif

  controller dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .start            (start),
    .read_done        (read_done),
    .calculation_done (calculation_done),
    .write_done       (write_done),
    .shift_done       (shift_done),
    .move_done        (move_done),
    .all_done         (all_done),
    .start_read       (start_read),
    .start_calculation(start_calculation),
    .start_write      (start_write),
    .start_shift      (start_shift),
    .start_move       (start_move)
`ifdef CONTROLLER_FRAME_DONE_EN
    ,
    .frame_done       (frame_done)
`endif
  );

  always #5 clk = ~clk;

  int   vecs = 0;
  int   errs = 0;
  // Reference: 0 = idle, 1..5 = read, calc, write, shift, move (one-hot bit ph-1 of the request word).
  int   ph = 0;
  logic fd_exp = 1'b0;

  function automatic logic [4:0] exp_req(int p);
    return (p == 0) ? 5'd0 : 5'(1 << (p - 1));
  endfunction

  function automatic logic [4:0] outs();
    return {start_move, start_shift, start_write, start_calculation, start_read};
  endfunction

  task automatic check(string tag, logic [4:0] obs, logic [4:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(logic s, logic r, logic c, logic w, logic sh, logic m, logic a);
    start = s; read_done = r; calculation_done = c;
    write_done = w; shift_done = sh; move_done = m; all_done = a;
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, then compare.
  task automatic step(string tag);
    logic [4:0] dn;
    dn = {move_done, shift_done, write_done, calculation_done, read_done};
    @(posedge clk);
    fd_exp = (ph == 3) && write_done && all_done;
    if (ph == 0) begin
      if (start) ph = 1;
    end else if (dn[ph-1]) begin
      if (ph == 3)      ph = all_done ? 0 : 4;
      else if (ph == 5) ph = 1;
      else              ph = ph + 1;
    end
    @(negedge clk);
    check(tag, outs(), exp_req(ph));
`ifdef CONTROLLER_FRAME_DONE_EN
    vecs++;
    assert (frame_done === fd_exp) else begin
      errs++;
      $error("FAIL %s_frame_done: observed %b expected %b", tag, frame_done, fd_exp);
    end
`endif
  endtask

  initial begin
    n_rst = 1'b1;
    drive(1, 1, 1, 1, 1, 1, 1);
    #1 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", outs(), 5'd0);

    n_rst = 1'b1;
    step("reset_release");

    // Idle hold after a fresh reset
    n_rst = 1'b0;
    #1;
    ph = 0; fd_exp = 1'b0;
    check("reset_async", outs(), 5'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (10) step("idle_hold");

    // Full loop, each done returned one cycle after its request
    drive(1, 0, 0, 0, 0, 0, 0); step("loop_read");
    drive(0, 1, 0, 0, 0, 0, 0); step("loop_calc");
    drive(0, 0, 1, 0, 0, 0, 0); step("loop_write");
    drive(0, 0, 0, 1, 0, 0, 0); step("loop_shift");
    drive(0, 0, 0, 0, 1, 0, 0); step("loop_move");
    drive(0, 0, 0, 0, 0, 1, 0); step("loop_reread");

    // Stall in CALC with foreign dones high
    drive(0, 1, 0, 0, 0, 0, 0); step("to_calc");
    drive(0, 0, 0, 1, 1, 1, 0);
    repeat (5) step("calc_stall");
    drive(0, 0, 1, 1, 1, 1, 0); step("calc_release");

    // Completion back to idle
    drive(0, 0, 0, 1, 0, 0, 1); step("complete");
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step("idle_after");

    // Mid-run reset while in SHIFT
    drive(1, 1, 1, 1, 1, 1, 0);
    repeat (4) step("to_shift");
    drive(0, 1, 1, 1, 0, 1, 0); step("shift_hold");
    #2 n_rst = 1'b0;
    #1;
    ph = 0; fd_exp = 1'b0;
    check("midrun_reset", outs(), 5'd0);
    @(negedge clk);
    start = 1'b0;
    n_rst = 1'b1;
    repeat (3) step("post_reset_idle");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 2) != 0),
            logic'($urandom_range(0, 2) != 0),
            logic'($urandom_range(0, 2) != 0),
            logic'($urandom_range(0, 2) != 0),
            logic'($urandom_range(0, 2) != 0),
            logic'($urandom_range(0, 7) == 0));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
